// File: rtl/div_seq_if.sv
// Handshake bundle between the EX stage and the sequential divider.
// EX drives operands and control; the divider returns result and status.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o,
    input  busy_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o,
    output busy_o
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer for DIV/DIVU in EX.
// Produces {remainder, quotient}; stalls EX via busy_o while working.
module div_seq #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               neg1, neg2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Operand magnitudes, one shift-subtract step and final sign fix-up
  always_comb begin
    neg1   = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    neg2   = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    abs1   = neg1 ? -bus.opdata1_i : bus.opdata1_i;
    abs2   = neg2 ? -bus.opdata2_i : bus.opdata2_i;
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, dsr_q};
    q_fix  = qneg_q ? -dvd_q : dvd_q;
    r_fix  = rneg_q ? -rem_q : rem_q;
  end

  // Next-state and datapath sequencing; annul forces IDLE from anywhere
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          dvd_d  = abs1;
          dsr_d  = abs2;
          rem_d  = '0;
          cnt_d  = '0;
          qneg_d = neg1 ^ neg2;
          rneg_d = neg1;
          if (bus.opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d = S_ON;
          end
        end
      end
      S_BYZERO: begin
        state_d  = S_END;
        result_d = '0;
      end
      S_ON: begin
        if (cnt_q == CW'(WIDTH)) begin
          state_d  = S_END;
          result_d = {r_fix, q_fix};
        end else begin
          rem_d = ge ? rem_sh[WIDTH-1:0] - dsr_q
                     : rem_sh[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ge};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_END: begin
        if (!bus.start_i) begin
          state_d  = S_IDLE;
          result_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (bus.annul_i) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = '0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // Status decode; busy includes the issue cycle so EX stalls at once
  always_comb begin
    bus.result_o = result_q;
    bus.ready_o  = state_q == S_END;
    bus.busy_o   = (state_q == S_BYZERO) | (state_q == S_ON) |
                   ((state_q == S_IDLE) & bus.start_i &
                    ~bus.annul_i);
  end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vectors plus random
// operations against an arithmetic reference and latency model.
module tb_div_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: cycles left until ready, pending and visible result
  int          m_left  = 0;
  logic        m_ready = 1'b0;
  logic [63:0] m_res   = '0;
  logic [63:0] m_pend  = '0;
  logic        exp_busy;

  function automatic logic [63:0] ref_div(
    input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic check64(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst || bus.annul_i) begin
      m_left  <= 0;
      m_ready <= 1'b0;
      m_res   <= '0;
    end else if (m_ready) begin
      if (!bus.start_i) begin
        m_ready <= 1'b0;
        m_res   <= '0;
      end
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        m_ready <= 1'b1;
        m_res   <= m_pend;
      end
      m_left <= m_left - 1;
    end else if (bus.start_i) begin
      m_pend <= ref_div(bus.signed_div_i,
                        bus.opdata1_i, bus.opdata2_i);
      m_left <= (bus.opdata2_i == 32'd0) ? 1 : W + 1;
    end
  end

  always @(negedge clk) begin
    exp_busy = (m_left > 0) ||
               (!m_ready && bus.start_i && !bus.annul_i);
    check64("ready", 64'(bus.ready_o), 64'(m_ready));
    check64("busy", 64'(bus.busy_o), 64'(exp_busy));
    check64("result", bus.result_o, m_res);
  end

  function automatic logic [31:0] pick();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return v;
    endcase
  endfunction

  // One operation; abort_at/rst_at give the count after E0 for
  // an annul or reset pulse (-1 = none). lat=-1 when aborted.
  task automatic run_op(input logic s,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int hold,
                        input int abort_at,
                        input int rst_at,
                        output logic [63:0] res,
                        output int lat);
    int k;
    res = '0;
    lat = -1;
    @(posedge clk); #2;
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
    k = 0;
    forever begin
      #2;
      if (k == abort_at) begin
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk); #2;
        bus.annul_i = 1'b0;
        return;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        return;
      end
      if (bus.ready_o) begin
        lat = k;
        res = bus.result_o;
        break;
      end
      if (k >= 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: no ready after %0d edges", k);
        bus.start_i = 1'b0;
        @(posedge clk); #2;
        return;
      end
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = 1'($urandom);
      @(posedge clk);
      k++;
    end
    repeat (hold) begin
      @(posedge clk); #2;
    end
    bus.start_i = 1'b0;
    @(posedge clk);
  endtask

  logic [63:0] res;
  int          lat;
  logic        rs;
  logic [31:0] ra, rb;

  initial begin
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    check64("rst_result", bus.result_o, 64'd0);
    check64("rst_ready", 64'(bus.ready_o), 64'd0);
    check64("rst_busy", 64'(bus.busy_o), 64'd0);

    check64("ref1", ref_div(1'b1, 32'hFFFFFFE2, 32'd6),
            64'h00000000_FFFFFFFB);
    check64("ref2", ref_div(1'b1, 32'hFFFFFFE1, 32'd6),
            64'hFFFFFFFF_FFFFFFFB);
    check64("ref3", ref_div(1'b0, 32'hFFFFFFE2, 32'd6),
            64'h00000004_2AAAAAA5);
    check64("ref4", ref_div(1'b1, 32'h80000000, 32'hFFFFFFFF),
            64'h00000000_80000000);
    check64("ref5", ref_div(1'b1, 32'h12345678, 32'd0), 64'd0);

    run_op(1'b1, 32'hFFFFFFE2, 32'd6, 0, -1, -1, res, lat);
    check64("t1_res", res, 64'h00000000_FFFFFFFB);
    check64("t1_lat", 64'(lat), 64'd33);
    run_op(1'b1, 32'hFFFFFFE1, 32'd6, 0, -1, -1, res, lat);
    check64("t2_res", res, 64'hFFFFFFFF_FFFFFFFB);
    run_op(1'b0, 32'hFFFFFFE2, 32'd6, 0, -1, -1, res, lat);
    check64("t3_res", res, 64'h00000004_2AAAAAA5);
    check64("t3_lat", 64'(lat), 64'd33);
    run_op(1'b1, 32'h12345678, 32'd0, 0, -1, -1, res, lat);
    check64("t4_zres", res, 64'd0);
    check64("t4_zlat", 64'(lat), 64'd1);
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, -1, -1,
           res, lat);
    check64("t4_ovf", res, 64'h00000000_80000000);

    run_op(1'b1, 32'hFFFFFFE2, 32'd6, 0, 10, -1, res, lat);
    check64("t5_annul_rdy", 64'(bus.ready_o), 64'd0);
    check64("t5_annul_busy", 64'(bus.busy_o), 64'd0);
    run_op(1'b1, 32'hFFFFFFE2, 32'd6, 0, -1, 20, res, lat);
    check64("t5_rst_rdy", 64'(bus.ready_o), 64'd0);
    check64("t5_rst_busy", 64'(bus.busy_o), 64'd0);
    run_op(1'b1, 32'hFFFFFFE1, 32'd6, 0, -1, -1, res, lat);
    check64("t5_fresh", res, 64'hFFFFFFFF_FFFFFFFB);

    run_op(1'b0, 32'd100, 32'd7, 5, -1, -1, res, lat);
    check64("t6_res", res, 64'h00000002_0000000E);
    #2;
    check64("t6_drop_res", bus.result_o, 64'd0);
    check64("t6_drop_rdy", 64'(bus.ready_o), 64'd0);

    for (int i = 0; i < 300; i++) begin
      rs = 1'($urandom);
      ra = pick();
      rb = pick();
      run_op(rs, ra, rb, $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0) ?
               int'($urandom_range(0, 35)) : -1,
             -1, res, lat);
      if (lat >= 0) check64("rand_res", res, ref_div(rs, ra, rb));
    end

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
